// File: rtl/paillier_bignum_pkg.sv
// Shared big-number types: FSM state encoding, default word width and word-count helper.
// Used by the reduction block and any word-serial big-number stage built on it.
package paillier_bignum_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int words(input int k, input int n);
        return k / n;
    endfunction

endpackage

// File: rtl/word_sub_borrow.sv
// One N-bit slice of a ripple subtractor: o_diff = i_a - i_b - i_borrow.
// Purely combinational, zero latency, no flow control.
module word_sub_borrow #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_borrow,
    output logic [N-1:0] o_diff,
    output logic         o_borrow
);

    logic [N:0] w_full;

    // Borrow-out appears as bit N of the zero-extended difference
    assign w_full   = {1'b0, i_a} - {1'b0, i_b} - {{N{1'b0}}, i_borrow};
    assign o_diff   = w_full[N-1:0];
    assign o_borrow = w_full[N];

endmodule

// File: rtl/big_num_mod_reduce.sv
// X mod M for X = {carry,sum} < 2M using one word-serial conditional subtraction.
// Latency: out_valid rises K/N edges after the accepting edge.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE with start low.
module big_num_mod_reduce
    import paillier_bignum_pkg::*;
#(
    parameter int K = 128,
    parameter int N = WORD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         carry,
    input  logic [K-1:0] sum,
    input  logic [K-1:0] modulus,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [K-1:0] result
);

    localparam int W  = words(K, N);
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    generate
        if (K % N != 0) begin : g_bad_width
            $fatal(1, "big_num_mod_reduce: K must be a multiple of N");
        end
    endgenerate

    state_t         r_state;
    state_t         w_next_state;
    logic [K-1:0]   r_x;
    logic [K-1:0]   r_m;
    logic [K-1:0]   r_d;
    logic [K-1:0]   r_result;
    logic           r_carry;
    logic           r_borrow;
    logic [IW-1:0]  r_idx;

    logic [N-1:0]   w_diff;
    logic           w_bout;
    logic           w_last;
    logic           w_accept;
    logic           w_ge;
    logic [K-1:0]   w_x_rot;
    logic [K-1:0]   w_d_next;

    word_sub_borrow #(.N(N)) u_word_sub (
        .i_a      (r_x[N-1:0]),
        .i_b      (r_m[N-1:0]),
        .i_borrow (r_borrow),
        .o_diff   (w_diff),
        .o_borrow (w_bout)
    );

    // X rotates rather than shifts so that after W words it is back in place,
    // which gives the unreduced fallback without a second copy of X.
    assign w_x_rot  = (r_x >> N) | (r_x << (K - N));
    assign w_d_next = (r_d >> N) | (K'(w_diff) << (K - N));
    assign w_last   = (r_idx == IW'(W - 1));
    assign w_ge     = r_carry | ~w_bout;

    assign in_ready  = (r_state == IDLE) && !start;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == DONE);
    assign result    = r_result;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = SUB;
            SUB:     if (w_last) w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        if (start) w_next_state = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x      <= '0;
            r_m      <= '0;
            r_d      <= '0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
        end else if (start) begin
            r_borrow <= 1'b0;
            r_idx    <= '0;
        end else if (w_accept) begin
            r_x      <= sum;
            r_m      <= modulus;
            r_d      <= '0;
            r_carry  <= carry;
            r_borrow <= 1'b0;
            r_idx    <= '0;
        end else if (r_state == SUB) begin
            r_x      <= w_x_rot;
            r_m      <= r_m >> N;
            r_d      <= w_d_next;
            r_borrow <= w_bout;
            r_idx    <= r_idx + IW'(1);
            if (w_last) begin
                r_result <= w_ge ? w_d_next : w_x_rot;
            end
        end
    end

endmodule

// File: tb/tb_big_num_mod_reduce.sv
// Directed-vector bench for big_num_mod_reduce (K=128, N=32) with a queue-based scoreboard.
module tb_big_num_mod_reduce;

    localparam int K = 128;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         carry = 1'b0;
    logic [K-1:0] sum = '0;
    logic [K-1:0] modulus = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [K-1:0] result;

    logic [K-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    big_num_mod_reduce #(.K(K), .N(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .carry     (carry),
        .sum       (sum),
        .modulus   (modulus),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: every retired result is checked against the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got %h expected no output", result);
            end else begin
                check("scoreboard_result", result, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic op(input logic c, input logic [K-1:0] s, input logic [K-1:0] m,
                      input logic [K-1:0] e, input bit wait_retire);
        int t;
        int lat;
        carry    = c;
        sum      = s;
        modulus  = m;
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", K'(in_ready), K'(1));
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency_edges", K'(lat), K'(4));
        if (wait_retire) begin
            t = 0;
            while (out_valid && t < 50) begin
                @(posedge clk);
                #1;
                t++;
            end
        end
    endtask

    task automatic abort_test(input bit use_rst);
        bit seen;
        carry    = 1'b0;
        sum      = K'(20);
        modulus  = K'(7);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        if (use_rst) rst = 1'b1;
        else begin
            start = 1'b1;
            #1;
            check("in_ready_low_during_start", K'(in_ready), K'(0));
        end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        #1;
        check(use_rst ? "rst_abort_in_ready" : "start_abort_in_ready", K'(in_ready), K'(1));
        check(use_rst ? "rst_abort_out_valid" : "start_abort_out_valid", K'(out_valid), K'(0));
        if (use_rst) check("rst_abort_result_cleared", result, K'(0));
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check(use_rst ? "rst_abort_no_output" : "start_abort_no_output", K'(seen), K'(0));
    endtask

    initial begin
        logic [K-1:0] all_ones;
        all_ones = '1;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset_in_ready", K'(in_ready), K'(1));
        check("reset_out_valid", K'(out_valid), K'(0));
        check("reset_result", result, K'(0));

        op(1'b0, K'(5), K'(7), K'(5), 1'b1);
        op(1'b0, K'(7), K'(7), K'(0), 1'b1);
        op(1'b1, all_ones - K'(3), all_ones, all_ones - K'(2), 1'b1);
        op(1'b0, K'(64'h1_0000_0000), K'(32'hFFFF_FFFF), K'(1), 1'b1);
        op(1'b0, {64'h1, 64'h0}, {64'h1, 64'h5}, {64'h1, 64'h0}, 1'b1);

        // Backpressure: result must hold while out_ready is low
        out_ready = 1'b0;
        op(1'b0, K'(13), K'(10), K'(3), 1'b0);
        for (int i = 0; i < 10; i++) begin
            check("hold_out_valid", K'(out_valid), K'(1));
            check("hold_result", result, K'(3));
            check("hold_in_ready", K'(in_ready), K'(0));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("retire_in_ready", K'(in_ready), K'(1));
        check("retire_out_valid", K'(out_valid), K'(0));
        op(1'b0, K'(16'h1234), K'(16'h1000), K'(16'h0234), 1'b1);

        // start wins over in_valid in IDLE
        carry    = 1'b0;
        sum      = K'(1);
        modulus  = K'(7);
        in_valid = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        check("start_gates_in_ready", K'(in_ready), K'(0));
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("start_no_accept", K'(in_ready), K'(1));

        abort_test(1'b0);
        op(1'b0, K'(9), K'(7), K'(2), 1'b1);
        abort_test(1'b1);
        op(1'b0, K'(9), K'(7), K'(2), 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", K'(exp_q.size()), K'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
